// File: rtl/bus_arbiter5_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_arbiter5_if : request/grant bundle for the 5-way bus arbiter     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface bus_arbiter5_if;
   logic [4:0] req;
   logic [4:0] gnt;
   logic [2:0] sel;
   logic       busy;
   logic       preempt;

   modport master (output req, input gnt, input sel, input busy, input preempt);
   modport slave  (input req, output gnt, output sel, output busy, output preempt);
endinterface
`default_nettype wire

// File: rtl/bus_arbiter5.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_arbiter5 : 5-way round-robin arbiter with MAX_HOLD tenure limit  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module bus_arbiter5 #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  wire           clk,
   input  wire           reset,
   bus_arbiter5_if.slave bus
);

   localparam int unsigned c_HOLD_W = $clog2(MAX_HOLD + 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [4:0]          gnt_q, gnt_d;
   logic [2:0]          sel_q, sel_d;
   logic [2:0]          last_q, last_d;
   logic [c_HOLD_W-1:0] hold_q, hold_d;
   logic                preempt_q, preempt_d;

   logic                win_found;
   logic [2:0]          win_idx;
   logic [2:0]          cand;
   logic                release_now;

   // Scan in reverse priority so the nearest requester after last_q wins last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 3'd0;
      cand      = 3'd0;
      for (int k = 5; k >= 1; k--) begin
         cand = 3'((int'(last_q) + k) % 5);
         if (bus.req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      sel_d       = sel_q;
      last_d      = last_q;
      hold_d      = hold_q;
      preempt_d   = 1'b0;
      release_now = 1'b0;

      case (state_q)
         ST_IDLE: begin
            release_now = 1'b1;
         end
         ST_BUSY: begin
            // Voluntary release wins over the hold limit and suppresses preempt.
            if (!bus.req[sel_q]) begin
               release_now = 1'b1;
            end else if (hold_q == c_HOLD_W'(MAX_HOLD)) begin
               release_now = 1'b1;
               preempt_d   = 1'b1;
            end else begin
               hold_d = hold_q + c_HOLD_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = 5'b00000;
         end
      endcase

      if (release_now) begin
         if (win_found) begin
            state_d = ST_BUSY;
            gnt_d   = 5'b00001 << win_idx;
            sel_d   = win_idx;
            last_d  = win_idx;
            hold_d  = c_HOLD_W'(1);
         end else begin
            state_d = ST_IDLE;
            gnt_d   = 5'b00000;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         gnt_q     <= 5'b00000;
         sel_q     <= 3'd0;
         last_q    <= 3'd4;
         hold_q    <= '0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         sel_q     <= sel_d;
         last_q    <= last_d;
         hold_q    <= hold_d;
         preempt_q <= preempt_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.sel     = sel_q;
   assign bus.busy    = (state_q == ST_BUSY);
   assign bus.preempt = preempt_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter5.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bus_arbiter5 : directed self-checking bench for bus_arbiter5      |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_bus_arbiter5;

   localparam int unsigned c_MAX_HOLD = 8;
   localparam int          c_WAIT_MAX = 4 * c_MAX_HOLD + 1;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;
   int   waitc [5];
   int   worst;
   logic [4:0] r;

   bus_arbiter5_if bus_if ();

   bus_arbiter5 #(.MAX_HOLD(c_MAX_HOLD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Advance one edge, sample 1 ns later and check the always-true properties.
   task automatic step();
      @(posedge clk);
      #1;
      chk("onehot", 32'($countones(bus_if.gnt) <= 1), 32'd1);
      chk("sel_range", 32'(bus_if.sel < 3'd5), 32'd1);
      chk("busy_vs_gnt", 32'(bus_if.busy), 32'(|bus_if.gnt));
      if (bus_if.busy)
         chk("sel_vs_gnt", 32'(bus_if.gnt), 32'(5'b00001 << bus_if.sel));
   endtask

   task automatic expect_out(input string tag, input logic [4:0] g, input logic [2:0] s,
                             input logic b, input logic p);
      chk({tag, "_gnt"}, 32'(bus_if.gnt), 32'(g));
      chk({tag, "_sel"}, 32'(bus_if.sel), 32'(s));
      chk({tag, "_busy"}, 32'(bus_if.busy), 32'(b));
      chk({tag, "_preempt"}, 32'(bus_if.preempt), 32'(p));
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      reset      = 1'b1;
      bus_if.req = 5'b00000;
      step();
      step();
      expect_out("reset", 5'b00000, 3'd0, 1'b0, 1'b0);

      // Requester 0 has top priority after reset, then rotation to 4.
      reset      = 1'b0;
      bus_if.req = 5'b10001;
      step();
      expect_out("first", 5'b00001, 3'd0, 1'b1, 1'b0);
      bus_if.req = 5'b10000;
      step();
      expect_out("rel0", 5'b10000, 3'd4, 1'b1, 1'b0);
      bus_if.req = 5'b00000;
      step();
      expect_out("idle", 5'b00000, 3'd4, 1'b0, 1'b0);
      step();
      expect_out("idle_hold", 5'b00000, 3'd4, 1'b0, 1'b0);

      // Single continuous requester: preempt pulse every MAX_HOLD cycles.
      bus_if.req = 5'b00100;
      step();
      expect_out("solo_g", 5'b00100, 3'd2, 1'b1, 1'b0);
      for (int rep = 0; rep < 2; rep++) begin
         for (int i = 1; i < c_MAX_HOLD; i++) begin
            step();
            chk("solo_hold_gnt", 32'(bus_if.gnt), 32'(5'b00100));
            chk("solo_hold_pre", 32'(bus_if.preempt), 32'd0);
         end
         step();
         expect_out("solo_regrant", 5'b00100, 3'd2, 1'b1, 1'b1);
      end

      // Hand over to owner 3, then all request: forced rotation 4,0,1,2,3.
      bus_if.req = 5'b01000;
      step();
      expect_out("to3", 5'b01000, 3'd3, 1'b1, 1'b0);
      bus_if.req = 5'b11111;
      r = 5'b01000;
      for (int e = 0; e < 5; e++) begin
         for (int i = 1; i < c_MAX_HOLD; i++) begin
            step();
            chk("rot_hold", 32'(bus_if.gnt), 32'(r));
         end
         step();
         case (e)
            0: r = 5'b10000;
            1: r = 5'b00001;
            2: r = 5'b00010;
            3: r = 5'b00100;
            default: r = 5'b01000;
         endcase
         chk("rot_gnt", 32'(bus_if.gnt), 32'(r));
         chk("rot_pre", 32'(bus_if.preempt), 32'd1);
      end

      // Owner 1 releases with nobody else requesting -> idle, sel keeps 1.
      bus_if.req = 5'b00010;
      step();
      expect_out("to1", 5'b00010, 3'd1, 1'b1, 1'b0);
      bus_if.req = 5'b00000;
      step();
      expect_out("drop1", 5'b00000, 3'd1, 1'b0, 1'b0);

      // Reset in the middle of owner 2's tenure at count 5.
      bus_if.req = 5'b00100;
      step();
      for (int i = 0; i < 4; i++) step();
      expect_out("mid2", 5'b00100, 3'd2, 1'b1, 1'b0);
      reset = 1'b1;
      step();
      expect_out("midreset", 5'b00000, 3'd0, 1'b0, 1'b0);
      reset      = 1'b0;
      bus_if.req = 5'b00110;
      step();
      expect_out("postreset", 5'b00010, 3'd1, 1'b1, 1'b0);

      // Owner drops exactly at the hold limit: voluntary wins, no preempt.
      for (int i = 1; i < c_MAX_HOLD; i++) step();
      bus_if.req = 5'b00100;
      step();
      expect_out("vol_vs_forced", 5'b00100, 3'd2, 1'b1, 1'b0);

      // Random slowly-toggling requests with a starvation bound.
      for (int i = 0; i < 5; i++) waitc[i] = 0;
      r = bus_if.req;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int b = 0; b < 5; b++)
            if ($urandom_range(7) == 0) r[b] = ~r[b];
         bus_if.req = r;
         step();
         worst = 0;
         for (int b = 0; b < 5; b++) begin
            if (bus_if.req[b] && !bus_if.gnt[b]) waitc[b]++;
            else waitc[b] = 0;
            if (waitc[b] > worst) worst = waitc[b];
         end
         chk("starve_bound", 32'(worst <= c_WAIT_MAX), 32'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
